// File: rtl/cpu_pkg.sv
// Shared types for the simple RISC CPU controller: ISA opcodes, sequencer phases
// and the control strobe bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    OpHlt = 3'd0,
    OpSkz = 3'd1,
    OpAdd = 3'd2,
    OpAnd = 3'd3,
    OpXor = 3'd4,
    OpLda = 3'd5,
    OpSto = 3'd6,
    OpJmp = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    PhInstAddr  = 4'd0,
    PhInstFetch = 4'd1,
    PhInstLoad  = 4'd2,
    PhIdle      = 4'd3,
    PhOpAddr    = 4'd4,
    PhOpFetch   = 4'd5,
    PhAluOp     = 4'd6,
    PhStore     = 4'd7,
    PhHalted    = 4'd8
  } phase_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic inc_pc;
    logic ld_pc;
    logic data_e;
    logic halt;
  } ctrl_t;

  // Instructions that read an operand from memory into the accumulator path.
  function automatic logic is_aluop(opcode_t op);
    return (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe decode from (phase, opcode, zero); reset gating is applied
// by the caller.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  phase_t  i_phase,
  input  opcode_t i_opcode,
  input  logic    i_zero,
  output ctrl_t   o_ctrl
);

  logic w_aluop;
  logic w_jmp;
  logic w_sto;

  assign w_aluop = is_aluop(i_opcode);
  assign w_jmp   = (i_opcode == OpJmp);
  assign w_sto   = (i_opcode == OpSto);

  always_comb begin
    o_ctrl = '0;
    unique case (i_phase)
      PhInstAddr: begin
        o_ctrl.sel = 1'b1;
      end
      PhInstFetch: begin
        o_ctrl.sel = 1'b1;
        o_ctrl.rd  = 1'b1;
      end
      PhInstLoad, PhIdle: begin
        o_ctrl.sel   = 1'b1;
        o_ctrl.rd    = 1'b1;
        o_ctrl.ld_ir = 1'b1;
      end
      PhOpAddr: begin
        o_ctrl.inc_pc = (i_opcode != OpHlt);
        o_ctrl.halt   = (i_opcode == OpHlt);
      end
      PhOpFetch: begin
        o_ctrl.rd = w_aluop;
      end
      PhAluOp: begin
        o_ctrl.rd     = w_aluop;
        o_ctrl.inc_pc = (i_opcode == OpSkz) && i_zero;
        o_ctrl.ld_pc  = w_jmp;
        o_ctrl.data_e = w_sto;
      end
      PhStore: begin
        // JMP raises both PC strobes here; the PC gives load priority.
        o_ctrl.rd     = w_aluop;
        o_ctrl.inc_pc = w_jmp;
        o_ctrl.ld_pc  = w_jmp;
        o_ctrl.ld_ac  = w_aluop;
        o_ctrl.wr     = w_sto;
        o_ctrl.data_e = w_sto;
      end
      PhHalted: begin
        o_ctrl.halt = 1'b1;
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Central sequencer: steps the 8-phase instruction cycle, parks in HALTED on HLT,
// and drives the PC, memory, IR, accumulator and bus strobes.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_opcode,
  input  logic       i_zero,
  output logic       o_sel,
  output logic       o_rd,
  output logic       o_wr,
  output logic       o_ld_ir,
  output logic       o_ld_ac,
  output logic       o_inc_pc,
  output logic       o_ld_pc,
  output logic       o_data_e,
  output logic       o_halt
);

  phase_t  r_phase;
  phase_t  w_phase_next;
  opcode_t w_opcode;
  ctrl_t   w_ctrl;
  ctrl_t   w_ctrl_out;

  assign w_opcode = opcode_t'(i_opcode);

  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      PhOpAddr: w_phase_next = (w_opcode == OpHlt) ? PhHalted : PhOpFetch;
      PhStore:  w_phase_next = PhInstAddr;
      PhHalted: w_phase_next = PhHalted;
      default:  w_phase_next = phase_t'(r_phase + 4'd1);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase <= PhInstAddr;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  cpu_ctrl_decode u_decode (
    .i_phase  (r_phase),
    .i_opcode (w_opcode),
    .i_zero   (i_zero),
    .o_ctrl   (w_ctrl)
  );

  // Reset masks strobes in the same cycle, whatever phase is registered.
  assign w_ctrl_out = i_rst ? '0 : w_ctrl;

  assign o_sel    = w_ctrl_out.sel;
  assign o_rd     = w_ctrl_out.rd;
  assign o_wr     = w_ctrl_out.wr;
  assign o_ld_ir  = w_ctrl_out.ld_ir;
  assign o_ld_ac  = w_ctrl_out.ld_ac;
  assign o_inc_pc = w_ctrl_out.inc_pc;
  assign o_ld_pc  = w_ctrl_out.ld_pc;
  assign o_data_e = w_ctrl_out.data_e;
  assign o_halt   = w_ctrl_out.halt;

endmodule
